// File: rtl/run_detect_fsm_if.sv
// run_detect_fsm_if: signal bundle between the run detector and whoever drives it.
//   master : drives w, en, pol, clr; observes z, z_rise, run_cnt, evt_cnt
//   slave  : the detector itself (opposite directions)
// RUN_LEN and EVT_W must match the parameters of the attached run_detect_fsm.
interface run_detect_fsm_if #(
  parameter int unsigned RUN_LEN = 2,
  parameter int unsigned EVT_W   = 8
);
  localparam int unsigned RW = $clog2(RUN_LEN + 1);

  logic             w;
  logic             en;
  logic             pol;
  logic             clr;
  logic             z;
  logic             z_rise;
  logic [RW-1:0]    run_cnt;
  logic [EVT_W-1:0] evt_cnt;

  modport master (
    output w, en, pol, clr,
    input  z, z_rise, run_cnt, evt_cnt
  );

  modport slave (
    input  w, en, pol, clr,
    output z, z_rise, run_cnt, evt_cnt
  );
endinterface

// File: rtl/run_detect_fsm.sv
// run_detect_fsm: Moore run-length detector. z goes high once w has equalled pol on
// RUN_LEN consecutive enabled cycles and stays high until an enabled miss.
// Ports:
//   clk     : system clock, rising edge
//   resetn  : asynchronous reset, active-high (name kept from the existing codebase)
//   bus     : run_detect_fsm_if.slave
//             w       sampled serial input
//             en      sample enable; 0 holds state and counters
//             pol     match polarity, hit = (w == pol)
//             clr     synchronous clear of evt_cnt
//             z       high while in DETECT
//             z_rise  one-cycle pulse in the first DETECT cycle
//             run_cnt current run length, saturates at RUN_LEN
//             evt_cnt saturating count of entries into DETECT
module run_detect_fsm #(
  parameter int unsigned RUN_LEN = 2,
  parameter int unsigned EVT_W   = 8
) (
  input logic               clk,
  input logic               resetn,
  run_detect_fsm_if.slave   bus
);

  localparam int unsigned RW = $clog2(RUN_LEN + 1);
  localparam logic [RW-1:0]    RunMax = RW'(RUN_LEN);
  localparam logic [EVT_W-1:0] EvtMax = '1;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StCount  = 2'b01,
    StDetect = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [RW-1:0]    run_q, run_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic             rise_q, rise_d;
  logic             hit;
  logic             entry;

  assign hit = (bus.w == bus.pol);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    entry   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.en && hit) begin
          run_d = RW'(1);
          if (RUN_LEN == 1) begin
            state_d = StDetect;
            entry   = 1'b1;
          end else begin
            state_d = StCount;
          end
        end
      end
      StCount: begin
        if (bus.en) begin
          if (hit) begin
            run_d = run_q + RW'(1);
            if (run_q + RW'(1) == RunMax) begin
              state_d = StDetect;
              entry   = 1'b1;
            end
          end else begin
            state_d = StIdle;
            run_d   = '0;
          end
        end
      end
      StDetect: begin
        // A hit keeps run_cnt pinned at RUN_LEN; any miss restarts from scratch.
        if (bus.en && !hit) begin
          state_d = StIdle;
          run_d   = '0;
        end
      end
      default: begin
        // Unused encoding recovers to IDLE regardless of en.
        state_d = StIdle;
        run_d   = '0;
      end
    endcase
  end

  // en=0 forces the pulse low because entry can only be set when en is high.
  always_comb begin
    rise_d = entry;
    evt_d  = evt_q;
    if (bus.clr) begin
      evt_d = '0;
    end else if (entry && (evt_q != EvtMax)) begin
      evt_d = evt_q + EVT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q <= StIdle;
      run_q   <= '0;
      evt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      evt_q   <= evt_d;
      rise_q  <= rise_d;
    end
  end

  // Outputs depend on registered state only; an unused encoding reads as IDLE.
  assign bus.z       = (state_q == StDetect);
  assign bus.z_rise  = rise_q && (state_q == StDetect);
  assign bus.run_cnt = ((state_q == StCount) || (state_q == StDetect)) ? run_q : '0;
  assign bus.evt_cnt = evt_q;

endmodule

// File: tb/tb_run_detect_fsm.sv
// Drives three detector instances (RUN_LEN 1/3/4, one with a 2-bit event counter) with
// the same stimulus and compares each against a run-length reference model.
module tb_run_detect_fsm;

  localparam int unsigned L0 = 1, E0 = 8;
  localparam int unsigned L1 = 3, E1 = 2;
  localparam int unsigned L2 = 4, E2 = 8;

  logic clk;
  logic resetn;

  run_detect_fsm_if #(.RUN_LEN(L0), .EVT_W(E0)) if0 ();
  run_detect_fsm_if #(.RUN_LEN(L1), .EVT_W(E1)) if1 ();
  run_detect_fsm_if #(.RUN_LEN(L2), .EVT_W(E2)) if2 ();

  run_detect_fsm #(.RUN_LEN(L0), .EVT_W(E0)) dut0 (.clk(clk), .resetn(resetn), .bus(if0));
  run_detect_fsm #(.RUN_LEN(L1), .EVT_W(E1)) dut1 (.clk(clk), .resetn(resetn), .bus(if1));
  run_detect_fsm #(.RUN_LEN(L2), .EVT_W(E2)) dut2 (.clk(clk), .resetn(resetn), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: a run is just a count of consecutive enabled hits, capped at RUN_LEN.
  int lens [3] = '{L0, L1, L2};
  int emax [3] = '{(1 << E0) - 1, (1 << E1) - 1, (1 << E2) - 1};
  int run_m  [3];
  int rise_m [3];
  int evt_m  [3];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      run_m[d]  = 0;
      rise_m[d] = 0;
      evt_m[d]  = 0;
    end
  endtask

  task automatic model_step(input logic w, input logic en, input logic pol, input logic clr);
    for (int d = 0; d < 3; d++) begin
      int entered;
      entered = 0;
      if (en) begin
        if (w == pol) begin
          if (run_m[d] + 1 == lens[d]) entered = 1;
          run_m[d] = (run_m[d] + 1 > lens[d]) ? lens[d] : run_m[d] + 1;
        end else begin
          run_m[d] = 0;
        end
      end
      rise_m[d] = entered;
      if (clr) evt_m[d] = 0;
      else if (entered && evt_m[d] < emax[d]) evt_m[d] = evt_m[d] + 1;
    end
  endtask

  task automatic check_dut(input int d, input string tag, input logic z, input logic zr,
                           input int run, input int evt);
    check($sformatf("%s d%0d z", tag, d), int'(z), (run_m[d] == lens[d]) ? 1 : 0);
    check($sformatf("%s d%0d z_rise", tag, d), int'(zr), rise_m[d]);
    check($sformatf("%s d%0d run_cnt", tag, d), run, run_m[d]);
    check($sformatf("%s d%0d evt_cnt", tag, d), evt, evt_m[d]);
  endtask

  task automatic check_all(input string tag);
    check_dut(0, tag, if0.z, if0.z_rise, int'(if0.run_cnt), int'(if0.evt_cnt));
    check_dut(1, tag, if1.z, if1.z_rise, int'(if1.run_cnt), int'(if1.evt_cnt));
    check_dut(2, tag, if2.z, if2.z_rise, int'(if2.run_cnt), int'(if2.evt_cnt));
  endtask

  task automatic drive(input logic w, input logic en, input logic pol, input logic clr);
    if0.w = w; if0.en = en; if0.pol = pol; if0.clr = clr;
    if1.w = w; if1.en = en; if1.pol = pol; if1.clr = clr;
    if2.w = w; if2.en = en; if2.pol = pol; if2.clr = clr;
  endtask

  // Called at least 1 time unit after an edge; the check lands 1 unit after the next one.
  task automatic step(input string tag, input logic w, input logic en, input logic pol,
                      input logic clr);
    drive(w, en, pol, clr);
    @(posedge clk);
    model_step(w, en, pol, clr);
    #1;
    check_all(tag);
  endtask

  // Reset asserted between edges must clear outputs without any clock edge.
  task automatic async_reset(input string tag);
    #2;
    resetn = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    resetn = 1'b0;
  endtask

  initial begin
    resetn = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    resetn = 1'b0;

    // Basic run of ones, then a miss.
    step("basic", 1'b1, 1'b1, 1'b1, 1'b0);
    step("basic", 1'b1, 1'b1, 1'b1, 1'b0);
    step("basic", 1'b1, 1'b1, 1'b1, 1'b0);
    step("basic", 1'b0, 1'b1, 1'b1, 1'b0);

    // Near-miss then full run for the RUN_LEN=4 instance.
    for (int i = 0; i < 8; i++) step("len4", (i == 3) ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b0);

    // Runs of zeros with pol=0, then same data with pol=1.
    for (int i = 0; i < 3; i++) step("pol0", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("pol1", 1'b0, 1'b1, 1'b1, 1'b0);

    // Enable gaps inside a run.
    begin
      logic [4:0] en_pat;
      en_pat = 5'b11001;
      for (int i = 0; i < 5; i++) step("en_gap", 1'b1, en_pat[i], 1'b1, 1'b0);
    end
    step("en_gap_miss", 1'b0, 1'b1, 1'b1, 1'b0);

    // Repeated entries to saturate the 2-bit counter, then clr coinciding with an entry.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 3; i++) step("sat", 1'b1, 1'b1, 1'b1, 1'b0);
      step("sat_miss", 1'b0, 1'b1, 1'b1, 1'b0);
    end
    step("clr_entry", 1'b1, 1'b1, 1'b1, 1'b0);
    step("clr_entry", 1'b1, 1'b1, 1'b1, 1'b0);
    step("clr_entry", 1'b1, 1'b1, 1'b1, 1'b1);

    // Async reset in the middle of a run, then detection resumes.
    step("pre_rst", 1'b0, 1'b1, 1'b1, 1'b0);
    step("pre_rst", 1'b1, 1'b1, 1'b1, 1'b0);
    async_reset("async_rst");
    step("post_rst", 1'b1, 1'b1, 1'b1, 1'b0);
    step("post_rst", 1'b1, 1'b1, 1'b1, 1'b0);

    // Randomized: hit-biased data so long runs occur, occasional pol flips, clr, resets.
    begin
      logic pol_r;
      logic w_r;
      pol_r = 1'b1;
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(0, 99) < 5) pol_r = ~pol_r;
        w_r = ($urandom_range(0, 99) < 80) ? pol_r : ~pol_r;
        step("rand", w_r, ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0, pol_r,
             ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
        if ($urandom_range(0, 299) == 0) async_reset("rand_rst");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/run_detect_fsm.md
Name: run_detect_fsm

Overview:
Parametrised Moore run-length detector. It asserts z once input w has matched a selectable polarity for RUN_LEN consecutive enabled clock cycles. It succeeds the fixed two-in-a-row detector and adds the following: configurable run length, polarity select, clock enable, a one-cycle detect pulse, a live run counter, and a saturating detection-event counter. It sits in front of the lab's control datapaths as a debounced "sustained condition" flag.

Parameters:
RUN_LEN, 2, consecutive matching samples required to enter DETECT; legal range 1..255.
EVT_W, 8, width of event counter evt_cnt.
RW, $clog2(RUN_LEN+1) (localparam), width of run_cnt.

Ports:
clk  input  1  system clock, all state updates on rising edge
resetn  input  1  asynchronous reset, active-high (asserted = 1), single clock domain; port name kept as codebase convention
w  input  1  sampled serial input
en  input  1  sample enable; when 0 FSM and counters hold
pol  input  1  match polarity: hit = (w == pol); 1 detects runs of ones, 0 runs of zeros
clr  input  1  synchronous clear of evt_cnt only
z  output  1  Moore detect flag, high iff state == DETECT
z_rise  output  1  registered one-cycle pulse, first cycle in DETECT
run_cnt  output  RW  current run length, saturates at RUN_LEN
evt_cnt  output  EVT_W  number of IDLE/COUNT->DETECT entries, saturating

Behaviour:
- Reset (resetn=1, async): state=IDLE, z=0, z_rise=0, run_cnt=0, evt_cnt=0. Holds while asserted; first update on the first rising edge after deassertion.
- States: IDLE (run_cnt=0), COUNT (0<run_cnt<RUN_LEN), DETECT (run_cnt=RUN_LEN). Encoding 2 bits; unused code -> IDLE next cycle, all outputs as IDLE.
- hit = (w == pol), evaluated each edge; pol may change any cycle, no history kept.
- en=0: state, run_cnt, z, evt_cnt hold; z_rise forced 0; clr still honoured.
- IDLE, en&hit: run_cnt<=1; next = DETECT if RUN_LEN==1 else COUNT.
- COUNT, en&hit: run_cnt<=run_cnt+1; next = DETECT when run_cnt+1==RUN_LEN else COUNT.
- COUNT or DETECT, en&!hit: next = IDLE, run_cnt<=0 (a single miss restarts the run, no partial credit).
- DETECT, en&hit: stay, run_cnt holds at RUN_LEN.
- z is Moore: a function of registered state only, no combinational path from w, en, or pol.
- Latency: the match sampled on edge k (k = RUN_LEN-th consecutive) gives z=1 in the cycle following edge k. z drops in the cycle after the edge that samples a miss.
- z_rise=1 exactly in the first cycle after entry into DETECT, otherwise 0. Re-entry after leaving produces a new pulse.
- evt_cnt: +1 on each entry into DETECT; saturates at 2^EVT_W-1 (no wrap).
- clr: evt_cnt<=0 on the edge. If clr and an entry coincide, clr wins (result 0). clr does not affect the FSM.
- Reset mid-run: immediate return to IDLE values; the run is lost.

Test Plan:
- Reset, RUN_LEN=2, pol=1, en=1, w=1,1,1,0 -> z=0,1,1,0 after successive edges; z_rise=0,1,0,0; run_cnt=1,2,2,0; evt_cnt ends 1.
- RUN_LEN=4, w=1,1,1,0,1,1,1,1 -> z first high after 8th edge only; run_cnt=1,2,3,0,1,2,3,4; evt_cnt=1.
- pol=0, RUN_LEN=3, w=0,0,0 -> z=1 after 3rd edge; same sequence with pol=1 -> z stays 0, run_cnt 0.
- RUN_LEN=3, w=1 held, en pattern 1,0,0,1,1 -> run_cnt 1,1,1,2,3; z high only after last edge; z_rise single pulse.
- EVT_W=2, force 5 DETECT entries -> evt_cnt 1,2,3,3,3. Then clr=1 coincident with a 6th entry -> evt_cnt=0, z=1, z_rise=1.
- Assert resetn asynchronously mid-COUNT (between edges) -> z, z_rise, run_cnt, evt_cnt go 0 immediately without a clock edge. After release, w=1,1 -> detect resumes normally.
- RUN_LEN=1, w=1 -> z=1 after first edge, z_rise pulse, run_cnt=1.
